adder_tree_feeder: RTL and testbench



---
 rtl/adder_tree_pkg.sv | 27 ++
 rtl/lat_pipe.sv | 29 ++
 rtl/adder_tree_feeder.sv | 140 ++++++++++++++
 tb/tb_adder_tree_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared types and width helpers for the CSA adder tree and its stream feeder.
package adder_tree_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } feed_state_t;

    // Tag carried alongside a frame through the tree latency
    typedef struct packed {
        logic vld;
        logic is_short;
    } res_tag_t;

    localparam int unsigned RES_TAG_W = $bits(res_tag_t);

    function automatic int unsigned feed_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Sum of n words of w bits never exceeds w + clog2(n) bits
    function automatic int unsigned tree_o_data_w(input int unsigned w, input int unsigned n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// Generic reset-to-zero shift register; q is d delayed by DEPTH cycles.
module lat_pipe #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/adder_tree_feeder.sv
// Groups a word stream into zero-padded frames for the adder tree and tracks
// the tree latency so the matching result is flagged with res_vld/res_short.
module adder_tree_feeder
    import adder_tree_pkg::*;
#(
    parameter int unsigned I_DATA_W = 3,
    parameter int unsigned I_DATA_N = 4,
    parameter int unsigned TREE_LAT = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [I_DATA_W-1:0]                    s_data,
    input  logic                                   s_last,
    output logic [0:I_DATA_N-1][I_DATA_W-1:0]      t_data,
    output logic                                   t_vld,
    output logic                                   t_short,
    output logic                                   res_vld,
    output logic                                   res_short,
    output logic [15:0]                            frame_cnt
);

    localparam int unsigned CNT_W = feed_cnt_w(I_DATA_N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(I_DATA_N - 1);

    feed_state_t                              state_q, state_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]        buf_q, buf_d;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]        frame;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]        t_data_d;
    logic                                     t_vld_d;
    logic                                     t_short_d;
    logic                                     s_ready_d;
    logic                                     xfer;
    res_tag_t                                 tag_in, tag_out;

    assign xfer = s_valid && s_ready;

    // Closing frame: held words, current word at cnt, zeros above
    always_comb begin
        frame = '0;
        for (int unsigned i = 0; i < I_DATA_N; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                frame[i] = buf_q[i];
            end else if (CNT_W'(i) == cnt_q) begin
                frame[i] = s_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        t_data_d  = t_data;
        t_vld_d   = 1'b0;
        t_short_d = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        t_data_d = frame;
                        t_vld_d  = 1'b1;
                        cnt_d    = '0;
                        buf_d    = '0;
                        state_d  = IDLE;
                    end else if (s_last) begin
                        t_data_d  = frame;
                        t_vld_d   = 1'b1;
                        t_short_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = PAD;
                    end else begin
                        for (int unsigned i = 0; i < I_DATA_N; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                buf_d[i] = s_data;
                            end
                        end
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = FILL;
                    end
                end
            end
            PAD: begin
                buf_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                buf_d   = '0;
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d != PAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            t_data    <= '0;
            t_vld     <= 1'b0;
            t_short   <= 1'b0;
            s_ready   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            t_data  <= t_data_d;
            t_vld   <= t_vld_d;
            t_short <= t_short_d;
            s_ready <= s_ready_d;
            if (t_vld_d) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Frame tag follows t_data through the tree's pipeline depth
    assign tag_in = '{vld: t_vld, is_short: t_short};

    lat_pipe #(
        .W     (RES_TAG_W),
        .DEPTH (TREE_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tag_in),
        .q     (tag_out)
    );

    assign res_vld   = tag_out.vld;
    assign res_short = tag_out.is_short;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed self-checking bench for adder_tree_feeder at default parameters.
module tb_adder_tree_feeder;

    localparam int unsigned W = 3;
    localparam int unsigned N = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  s_valid;
    logic                  s_ready;
    logic [W-1:0]          s_data;
    logic                  s_last;
    logic [0:N-1][W-1:0]   t_data;
    logic                  t_vld;
    logic                  t_short;
    logic                  res_vld;
    logic                  res_short;
    logic [15:0]           frame_cnt;

    int n_run  = 0;
    int n_fail = 0;

    // Window monitor: counters clear while mon_en is low
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   vld_seen;
    int   res_seen;
    int   ready_drops;
    int   gap_bad;
    int   last_vld_cyc;
    logic gap_arm;

    adder_tree_feeder #(
        .I_DATA_W (W),
        .I_DATA_N (N),
        .TREE_LAT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .t_data    (t_data),
        .t_vld     (t_vld),
        .t_short   (t_short),
        .res_vld   (res_vld),
        .res_short (res_short),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!mon_en) begin
            vld_seen     = 0;
            res_seen     = 0;
            ready_drops  = 0;
            gap_bad      = 0;
            last_vld_cyc = 0;
            gap_arm      = 1'b0;
        end else begin
            if (res_vld) res_seen = res_seen + 1;
            if (rst_n && !s_ready) ready_drops = ready_drops + 1;
            if (t_vld) begin
                vld_seen = vld_seen + 1;
                if (gap_arm && (cyc - last_vld_cyc) != 4) gap_bad = gap_bad + 1;
                last_vld_cyc = cyc;
                gap_arm      = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run = n_run + 1;
        assert (obs === exp)
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sum_slots(input logic [0:N-1][W-1:0] v);
        int s = 0;
        for (int i = 0; i < N; i++) s = s + int'(v[i]);
        return s;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer
    task automatic send(input logic [W-1:0] d, input logic l);
        int w = 0;
        while (!s_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) chk("send_ready_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        idle(2);

        chk("rst_s_ready",   32'(s_ready),   32'd0);
        chk("rst_t_vld",     32'(t_vld),     32'd0);
        chk("rst_t_data",    32'(t_data),    32'd0);
        chk("rst_res_vld",   32'(res_vld),   32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Full frame 1,2,3,4
        send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd3, 1'b0); send(3'd4, 1'b1);
        chk("full_t_vld",   32'(t_vld),   32'd1);
        chk("full_t_data",  32'(t_data),  32'({3'd1, 3'd2, 3'd3, 3'd4}));
        chk("full_t_short", 32'(t_short), 32'd0);
        chk("full_res_early", 32'(res_vld), 32'd0);
        idle(2);
        chk("full_res_vld",   32'(res_vld),   32'd1);
        chk("full_res_short", 32'(res_short), 32'd0);
        chk("full_sum",       32'(sum_slots(t_data)), 32'd10);
        chk("full_frame_cnt", 32'(frame_cnt), 32'd1);

        // Short frame 5,6 -> one PAD bubble
        send(3'd5, 1'b0); send(3'd6, 1'b1);
        chk("short_t_vld",   32'(t_vld),   32'd1);
        chk("short_t_data",  32'(t_data),  32'({3'd5, 3'd6, 3'd0, 3'd0}));
        chk("short_t_short", 32'(t_short), 32'd1);
        chk("short_pad_ready", 32'(s_ready), 32'd0);
        idle(1);
        chk("short_ready_back", 32'(s_ready), 32'd1);
        idle(1);
        chk("short_res_vld",   32'(res_vld),   32'd1);
        chk("short_res_short", 32'(res_short), 32'd1);
        chk("short_sum",       32'(sum_slots(t_data)), 32'd11);

        // Gapped input 7,0,7,1 with 3 idle cycles between words
        mon_en = 1'b0;
        idle(1);
        mon_en = 1'b1;
        send(3'd7, 1'b0); idle(3);
        send(3'd0, 1'b0); idle(3);
        send(3'd7, 1'b0); idle(3);
        send(3'd1, 1'b1);
        chk("gap_t_data", 32'(t_data), 32'({3'd7, 3'd0, 3'd7, 3'd1}));
        idle(2);
        chk("gap_res_vld",  32'(res_vld), 32'd1);
        chk("gap_sum",      32'(sum_slots(t_data)), 32'd15);
        idle(2);
        chk("gap_vld_count", 32'(vld_seen), 32'd1);
        chk("gap_frame_cnt", 32'(frame_cnt), 32'd3);

        // Three full frames streamed back-to-back
        mon_en = 1'b0;
        do_reset();
        mon_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                send(3'(f + i), (i == 3));
            end
        end
        chk("b2b_t_data", 32'(t_data), 32'({3'd2, 3'd3, 3'd4, 3'd5}));
        idle(2);
        chk("b2b_vld_count",   32'(vld_seen),    32'd3);
        chk("b2b_gap_bad",     32'(gap_bad),     32'd0);
        chk("b2b_ready_drops", 32'(ready_drops), 32'd0);
        chk("b2b_frame_cnt",   32'(frame_cnt),   32'd3);

        // Reset mid-frame discards the partial frame
        mon_en = 1'b0;
        do_reset();
        mon_en = 1'b1;
        send(3'd6, 1'b0); send(3'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(s_ready), 32'd0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        send(3'd2, 1'b0); send(3'd4, 1'b0); send(3'd6, 1'b0); send(3'd1, 1'b1);
        chk("midrst_t_data", 32'(t_data), 32'({3'd2, 3'd4, 3'd6, 3'd1}));
        idle(2);
        chk("midrst_sum",       32'(sum_slots(t_data)), 32'd13);
        chk("midrst_vld_count", 32'(vld_seen),  32'd1);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Reset while a result is in flight drops it
        mon_en = 1'b0;
        idle(1);
        mon_en = 1'b1;
        send(3'd1, 1'b1);
        rst_n = 1'b0;
        idle(3);
        chk("inflight_res_dropped", 32'(res_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // One-word frame and three-word short frame
        send(3'd3, 1'b1);
        chk("one_t_data",  32'(t_data),  32'({3'd3, 3'd0, 3'd0, 3'd0}));
        chk("one_t_short", 32'(t_short), 32'd1);
        send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd3, 1'b1);
        chk("three_t_data",  32'(t_data),  32'({3'd1, 3'd2, 3'd3, 3'd0}));
        chk("three_t_short", 32'(t_short), 32'd1);
        chk("three_frame_cnt", 32'(frame_cnt), 32'd2);

        // frame_cnt wraps from 0xFFFF
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        chk("wrap_preload", 32'(frame_cnt), 32'h0000FFFF);
        send(3'd5, 1'b1);
        chk("wrap_t_vld",     32'(t_vld),     32'd1);
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
